// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter between the CPU MEM stage and the
// host/loader port.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CPU,
    OWN_HOST
  } owner_e;

  localparam int unsigned DMEM_DW = 32;
  localparam int unsigned DMEM_AW = 32;
  localparam int unsigned PERF_W  = 32;

  // Bits needed to hold 0..max_wait inclusive.
  function automatic int unsigned starve_w(input int unsigned max_wait);
    return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Free-running up-counter that sticks at all-ones; cleared by the synchronous active-low reset.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: CPU priority, host starvation guard and host burst lock.
// Optional stall/wait performance counters are enabled with DMEM_ARB_PERF_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DW       = DMEM_DW,
  parameter int unsigned AW       = DMEM_AW,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [AW-1:0]     cpu_addr,
  input  logic [DW-1:0]     cpu_wdata,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DW-1:0]     cpu_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [AW-1:0]     host_addr,
  input  logic [DW-1:0]     host_wdata,
  input  logic              host_lock,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DW-1:0]     host_rdata,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic [DW-1:0]     mem_rdata
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [PERF_W-1:0] cpu_stall_cycles,
  output logic [PERF_W-1:0] host_wait_cycles
`endif
);

  localparam int unsigned SW = starve_w(MAX_WAIT);
  localparam logic [SW-1:0] MaxWait = SW'(MAX_WAIT);

  owner_e        owner;
  logic          cpu_gnt;
  logic          host_wait;
  logic [SW-1:0] starve_q, starve_d;
  logic          lock_own_q, lock_own_d;
  logic          cpu_rvalid_q, cpu_rvalid_d;
  logic          host_rvalid_q, host_rvalid_d;

  // Grant decision; reset forces no owner so nothing reaches memory.
  always_comb begin
    owner = OWN_NONE;
    if (!reset) begin
      owner = OWN_NONE;
    end else if (lock_own_q && host_req) begin
      owner = OWN_HOST;
    end else if (host_req && (starve_q == MaxWait)) begin
      owner = OWN_HOST;
    end else if (cpu_req) begin
      owner = OWN_CPU;
    end else if (host_req) begin
      owner = OWN_HOST;
    end
  end

  assign cpu_gnt   = (owner == OWN_CPU);
  assign host_gnt  = (owner == OWN_HOST);
  assign cpu_stall = reset & cpu_req & ~cpu_gnt;
  assign host_wait = reset & host_req & ~host_gnt;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (owner)
      OWN_CPU: begin
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end
      OWN_HOST: begin
        mem_we    = host_we;
        mem_addr  = host_addr;
        mem_wdata = host_wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (!host_wait) begin
      starve_d = '0;
    end else if (starve_q != MaxWait) begin
      starve_d = starve_q + SW'(1);
    end
    // A lock can only be taken on a cycle the host actually owns the memory.
    lock_own_d    = host_gnt & host_lock;
    cpu_rvalid_d  = cpu_gnt & ~cpu_we;
    host_rvalid_d = host_gnt & ~host_we;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      starve_q      <= '0;
      lock_own_q    <= 1'b0;
      cpu_rvalid_q  <= 1'b0;
      host_rvalid_q <= 1'b0;
    end else begin
      starve_q      <= starve_d;
      lock_own_q    <= lock_own_d;
      cpu_rvalid_q  <= cpu_rvalid_d;
      host_rvalid_q <= host_rvalid_d;
    end
  end

  assign cpu_rvalid  = cpu_rvalid_q;
  assign host_rvalid = host_rvalid_q;
  assign cpu_rdata   = mem_rdata;
  assign host_rdata  = mem_rdata;

`ifdef DMEM_ARB_PERF_EN
  sat_counter #(
    .W(PERF_W)
  ) u_cpu_stall_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (cpu_stall),
    .count(cpu_stall_cycles)
  );

  sat_counter #(
    .W(PERF_W)
  ) u_host_wait_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (host_wait),
    .count(host_wait_cycles)
  );
`else
  // No counters in this build; arbitration is unaffected.
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed, table-driven bench for dmem_arbiter with MAX_WAIT=4, plus hand-written reset and
// performance-counter sequences.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam logic [31:0] CpuKey  = 32'hC0DE_0000;
  localparam logic [31:0] HostKey = 32'h0B57_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, cpu_stall, cpu_rvalid;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        host_req, host_we, host_lock, host_gnt, host_rvalid;
  logic [31:0] host_addr, host_wdata, host_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_ARB_PERF_EN
  logic [31:0] cpu_stall_cycles, host_wait_cycles;
`endif

  always #5 clk = ~clk;

  dmem_arbiter #(
    .DW      (32),
    .AW      (32),
    .MAX_WAIT(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_stall  (cpu_stall),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_lock  (host_lock),
    .host_gnt   (host_gnt),
    .host_rvalid(host_rvalid),
    .host_rdata (host_rdata),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
`ifdef DMEM_ARB_PERF_EN
    ,
    .cpu_stall_cycles(cpu_stall_cycles),
    .host_wait_cycles(host_wait_cycles)
`endif
  );

  typedef struct {
    bit          rst;
    bit          creq;
    bit          cwe;
    logic [31:0] caddr;
    bit          hreq;
    bit          hwe;
    logic [31:0] haddr;
    bit          hlock;
    logic [31:0] mrd;
    owner_e      own;
    bit          stall;
    bit          crv;
    bit          hrv;
  } vec_t;

  vec_t vq[$];
  int   n_pass = 0;
  int   n_total = 0;

  function automatic vec_t mk(input bit rst, input bit creq, input bit cwe,
                              input logic [31:0] caddr, input bit hreq, input bit hwe,
                              input logic [31:0] haddr, input bit hlock,
                              input logic [31:0] mrd, input owner_e own, input bit stall,
                              input bit crv, input bit hrv);
    vec_t v;
    v.rst = rst; v.creq = creq; v.cwe = cwe; v.caddr = caddr;
    v.hreq = hreq; v.hwe = hwe; v.haddr = haddr; v.hlock = hlock; v.mrd = mrd;
    v.own = own; v.stall = stall; v.crv = crv; v.hrv = hrv;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic drive(input vec_t v);
    reset      = v.rst;
    cpu_req    = v.creq;
    cpu_we     = v.cwe;
    cpu_addr   = v.caddr;
    cpu_wdata  = v.caddr ^ CpuKey;
    host_req   = v.hreq;
    host_we    = v.hwe;
    host_addr  = v.haddr;
    host_wdata = v.haddr ^ HostKey;
    host_lock  = v.hlock;
    mem_rdata  = v.mrd;
  endtask

  task automatic check(input vec_t v, input string tag);
    logic        e_we;
    logic [31:0] e_addr, e_wd;
    e_we = 1'b0; e_addr = '0; e_wd = '0;
    if (v.own == OWN_CPU) begin
      e_we = v.cwe; e_addr = v.caddr; e_wd = v.caddr ^ CpuKey;
    end else if (v.own == OWN_HOST) begin
      e_we = v.hwe; e_addr = v.haddr; e_wd = v.haddr ^ HostKey;
    end
    chk({tag, " host_gnt"},    32'(host_gnt),    32'(v.own == OWN_HOST));
    chk({tag, " cpu_stall"},   32'(cpu_stall),   32'(v.stall));
    chk({tag, " mem_we"},      32'(mem_we),      32'(e_we));
    chk({tag, " mem_addr"},    mem_addr,         e_addr);
    chk({tag, " mem_wdata"},   mem_wdata,        e_wd);
    chk({tag, " cpu_rvalid"},  32'(cpu_rvalid),  32'(v.crv));
    chk({tag, " host_rvalid"}, 32'(host_rvalid), 32'(v.hrv));
    if (v.crv) chk({tag, " cpu_rdata"}, cpu_rdata, v.mrd);
    if (v.hrv) chk({tag, " host_rdata"}, host_rdata, v.mrd);
  endtask

  initial begin
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, OWN_NONE, 0, 0, 0));

    // Reset held low: no grants even with both requesting.
    vq.push_back(mk(0, 1, 0, 32'h10, 1, 0, 32'h30, 0, 0, OWN_NONE, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 32'h0,  0, 0, 32'h0,  0, 0, OWN_NONE, 0, 0, 0));
    // CPU-only read and write.
    vq.push_back(mk(1, 1, 0, 32'h10, 0, 0, 32'h0,  0, 0, OWN_CPU,  0, 0, 0));
    vq.push_back(mk(1, 0, 0, 32'h0,  0, 0, 32'h0,  0, 32'hDEADBEEF, OWN_NONE, 0, 1, 0));
    vq.push_back(mk(1, 1, 1, 32'h20, 0, 0, 32'h0,  0, 0, OWN_CPU,  0, 0, 0));
    vq.push_back(mk(1, 0, 0, 32'h0,  0, 0, 32'h0,  0, 0, OWN_NONE, 0, 0, 0));
    // Host-only read.
    vq.push_back(mk(1, 0, 0, 32'h0,  1, 0, 32'h30, 0, 0, OWN_HOST, 0, 0, 0));
    vq.push_back(mk(1, 0, 0, 32'h0,  0, 0, 32'h0,  0, 32'hCAFEF00D, OWN_NONE, 0, 0, 1));
    // Alternating CPU then host reads.
    vq.push_back(mk(1, 1, 0, 32'h40, 0, 0, 32'h0,  0, 0, OWN_CPU,  0, 0, 0));
    vq.push_back(mk(1, 0, 0, 32'h0,  1, 0, 32'h44, 0, 32'h11111111, OWN_HOST, 0, 1, 0));
    vq.push_back(mk(1, 0, 0, 32'h0,  0, 0, 32'h0,  0, 32'h22222222, OWN_NONE, 0, 0, 1));
    // Contention: four CPU grants, then the starved host, then CPU again.
    vq.push_back(mk(1, 1, 0, 32'h50, 1, 0, 32'h60, 0, 1, OWN_CPU,  0, 0, 0));
    vq.push_back(mk(1, 1, 0, 32'h50, 1, 0, 32'h60, 0, 2, OWN_CPU,  0, 1, 0));
    vq.push_back(mk(1, 1, 0, 32'h50, 1, 0, 32'h60, 0, 3, OWN_CPU,  0, 1, 0));
    vq.push_back(mk(1, 1, 0, 32'h50, 1, 0, 32'h60, 0, 4, OWN_CPU,  0, 1, 0));
    vq.push_back(mk(1, 1, 0, 32'h50, 1, 0, 32'h60, 0, 5, OWN_HOST, 1, 1, 0));
    vq.push_back(mk(1, 1, 0, 32'h50, 1, 0, 32'h60, 0, 6, OWN_CPU,  0, 0, 1));
    vq.push_back(mk(1, 0, 0, 32'h0,  0, 0, 32'h0,  0, 7, OWN_NONE, 0, 1, 0));
    // Locked burst: host waits with lock asserted, wins by starvation, then keeps ownership.
    vq.push_back(mk(1, 1, 0, 32'h70, 1, 1, 32'h100, 1, 0, OWN_CPU,  0, 0, 0));
    vq.push_back(mk(1, 1, 0, 32'h70, 1, 1, 32'h100, 1, 0, OWN_CPU,  0, 1, 0));
    vq.push_back(mk(1, 1, 0, 32'h70, 1, 1, 32'h100, 1, 0, OWN_CPU,  0, 1, 0));
    vq.push_back(mk(1, 1, 0, 32'h70, 1, 1, 32'h100, 1, 0, OWN_CPU,  0, 1, 0));
    vq.push_back(mk(1, 1, 0, 32'h70, 1, 1, 32'h100, 1, 0, OWN_HOST, 1, 1, 0));
    vq.push_back(mk(1, 1, 0, 32'h70, 1, 1, 32'h104, 1, 0, OWN_HOST, 1, 0, 0));
    vq.push_back(mk(1, 1, 0, 32'h70, 1, 1, 32'h108, 1, 0, OWN_HOST, 1, 0, 0));
    vq.push_back(mk(1, 1, 0, 32'h70, 1, 1, 32'h10C, 0, 0, OWN_HOST, 1, 0, 0));
    vq.push_back(mk(1, 1, 0, 32'h70, 0, 0, 32'h0,   0, 0, OWN_CPU,  0, 0, 0));
    vq.push_back(mk(1, 0, 0, 32'h0,  0, 0, 32'h0,   0, 8, OWN_NONE, 0, 1, 0));
    // Reset with starve count at 3 must restart the count from 0.
    vq.push_back(mk(1, 1, 0, 32'h50, 1, 0, 32'h60, 0, 0, OWN_CPU,  0, 0, 0));
    vq.push_back(mk(1, 1, 0, 32'h50, 1, 0, 32'h60, 0, 0, OWN_CPU,  0, 1, 0));
    vq.push_back(mk(1, 1, 0, 32'h50, 1, 0, 32'h60, 0, 0, OWN_CPU,  0, 1, 0));
    vq.push_back(mk(0, 1, 0, 32'h50, 1, 0, 32'h60, 0, 0, OWN_NONE, 0, 1, 0));
    vq.push_back(mk(1, 1, 0, 32'h50, 1, 0, 32'h60, 0, 0, OWN_CPU,  0, 0, 0));
    vq.push_back(mk(1, 1, 0, 32'h50, 1, 0, 32'h60, 0, 0, OWN_CPU,  0, 1, 0));
    vq.push_back(mk(1, 1, 0, 32'h50, 1, 0, 32'h60, 0, 0, OWN_CPU,  0, 1, 0));
    vq.push_back(mk(1, 1, 0, 32'h50, 1, 0, 32'h60, 0, 0, OWN_CPU,  0, 1, 0));
    vq.push_back(mk(1, 1, 0, 32'h50, 1, 0, 32'h60, 0, 0, OWN_HOST, 1, 1, 0));
    vq.push_back(mk(1, 0, 0, 32'h0,  0, 0, 32'h0,  0, 9, OWN_NONE, 0, 0, 1));

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      drive(vq[i]);
      #2;
      check(vq[i], $sformatf("v%0d", i));
    end

    // Host read granted, then reset drops before the edge: its rvalid must never appear.
    @(negedge clk);
    drive(mk(1, 0, 0, 32'h0, 1, 0, 32'h200, 0, 0, OWN_HOST, 0, 0, 0));
    #2;
    check(mk(1, 0, 0, 32'h0, 1, 0, 32'h200, 0, 0, OWN_HOST, 0, 0, 0), "rst_a");
    #1;
    reset   = 1'b0;
    cpu_req = 1'b1;
    #1;
    check(mk(0, 1, 0, 32'h0, 1, 0, 32'h200, 0, 0, OWN_NONE, 0, 0, 0), "rst_b");
    @(negedge clk);
    drive(mk(0, 1, 0, 32'h0, 1, 0, 32'h200, 0, 0, OWN_NONE, 0, 0, 0));
    #2;
    check(mk(0, 1, 0, 32'h0, 1, 0, 32'h200, 0, 0, OWN_NONE, 0, 0, 0), "rst_c");

`ifdef DMEM_ARB_PERF_EN
    chk("perf_rst cpu_stall_cycles", cpu_stall_cycles, 32'd0);
    chk("perf_rst host_wait_cycles", host_wait_cycles, 32'd0);
    @(negedge clk);
    drive(mk(1, 1, 0, 32'h50, 1, 0, 32'h60, 0, 0, OWN_CPU, 0, 0, 0));
    repeat (10) @(posedge clk);
    @(negedge clk);
    drive(mk(1, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, OWN_NONE, 0, 0, 0));
    #2;
    chk("perf cpu_stall_cycles", cpu_stall_cycles, 32'd2);
    chk("perf host_wait_cycles", host_wait_cycles, 32'd8);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port synchronous data memory between the pipelined CPU data port (MEM stage) and a host/loader port, which preloads RSA keys and operands and reads back results.
- The CPU has priority by default. A starvation counter guarantees the host a slot. The host may lock the memory for bursts.
- The CPU is stalled while it is denied.
- Memory read latency is 1 cycle. Read data is returned with a registered valid to whichever port owned the access.

Parameters:
- DW, 32, data width.
- AW, 32, address width (byte address, passed through unchanged).
- MAX_WAIT, 4, consecutive denied host-request cycles before the host is forced a grant (≥1).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- cpu_req  in  1  CPU access request (MEM stage)
- cpu_we  in  1  CPU write enable
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_stall  out  1  stall CPU pipeline (request pending, not granted)
- cpu_rvalid  out  1  CPU read data valid
- cpu_rdata  out  DW  CPU read data
- host_req  in  1  host access request
- host_we  in  1  host write enable
- host_addr  in  AW  host address
- host_wdata  in  DW  host write data
- host_lock  in  1  host requests to keep ownership next cycle
- host_gnt  out  1  host access accepted this cycle
- host_rvalid  out  1  host read data valid
- host_rdata  out  DW  host read data
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data (1 cycle after address)

Behaviour:
- Grant is combinational from the current requests and registered state; exactly one of cpu_gnt (internal) or host_gnt is active, or neither.
- Priority, evaluated per cycle:
  1. Locked: if lock_own=1 and host_req=1, the host is granted.
  2. Otherwise, if host_req=1 and starve_cnt==MAX_WAIT, the host is granted.
  3. Otherwise, if cpu_req=1, the CPU is granted.
  4. Otherwise, if host_req=1, the host is granted.
- cpu_stall = cpu_req & ~cpu_gnt.
- Memory outputs:
  - mem_addr, mem_wdata and mem_we are muxed from the granted port.
  - With no grant: mem_we=0, mem_addr=0, mem_wdata=0.
- starve_cnt (registered):
  - Increments when host_req=1 and the host is denied, saturating at MAX_WAIT.
  - Clears to 0 on a host grant or when host_req=0.
- lock_own (registered):
  - Next value = host_gnt & host_lock.
  - Dropping host_lock or host_req releases the lock the next cycle.
  - The lock is never taken without a grant.
- Read return:
  - cpu_rvalid <= cpu_gnt & ~cpu_we.
  - host_rvalid <= host_gnt & ~host_we.
  - cpu_rdata and host_rdata = mem_rdata (pass-through); they are meaningful only when the matching rvalid=1.
- A write produces no rvalid. Back-to-back grants to alternating ports are legal; their rvalids alternate with the same 1-cycle offset.
- Requests are not queued: a denied requester must hold its req and fields stable until granted. The CPU does so via stall. A host that drops host_req while denied abandons the request.
- Reset (reset==0, sampled on the clk edge):
  - Registered state: starve_cnt=0, lock_own=0, cpu_rvalid=0, host_rvalid=0.
  - While reset is low, grants are forced to 0, which gives mem_we=0, host_gnt=0 and cpu_stall=0.
  - Reset mid-access discards any pending rvalid.
- Simultaneous events:
  - Lock and a CPU request together: the host wins. The CPU stalls for the whole lock duration; there is no CPU starvation guard.
  - starve_cnt==MAX_WAIT with cpu_req=1: the host wins for exactly one cycle unless host_lock is also set.

Optional Feature:
- Macro: DMEM_ARB_PERF_EN.
- When defined:
  - Adds output ports cpu_stall_cycles[31:0] and host_wait_cycles[31:0].
  - Both are saturating counters (stop at 0xFFFFFFFF) and clear on reset.
  - They increment on cycles where cpu_stall=1 and on cycles where the host is requesting but denied, respectively.
- When undefined: the ports and counters do not exist; arbitration behaviour is identical.

Decomposition:
- Package dmem_arb_pkg:
  - owner_e enum {OWN_NONE, OWN_CPU, OWN_HOST}.
  - Default DW/AW constants.
  - Counter width constant PERF_W=32.
- Sub-module sat_counter (parameter W; ports: inc, count). Used twice under DMEM_ARB_PERF_EN. It may also hold the starvation counter with a W sized from MAX_WAIT.

Test Plan:
- CPU only: CPU read addr 0x10 (mem returns 0xDEADBEEF next cycle) → cpu_stall=0; cpu_rvalid=1, cpu_rdata=0xDEADBEEF one cycle later; host_rvalid=0.
- Contention with MAX_WAIT=4: cpu_req and host_req both held high → CPU granted cycles 0–3, host_gnt=1 at cycle 4 with cpu_stall=1 that cycle, starve_cnt back to 0, CPU granted again at cycle 5.
- Host lock burst: host writes 0x100..0x10C with host_lock=1 while cpu_req=1 → 4 consecutive host_gnt; cpu_stall=1 for all 4 cycles; CPU granted on the cycle after host_lock drops.
- Alternating reads: CPU read at cycle 0, host read at cycle 1 → cpu_rvalid at cycle 1, host_rvalid at cycle 2, each carrying the corresponding mem_rdata.
- Reset mid-access: host read granted, reset=0 on the next edge → host_rvalid=0, mem_we=0, no grants while reset is low; the first request after release is granted normally with starve_cnt=0.
- With DMEM_ARB_PERF_EN, continuous contention for 10 cycles with MAX_WAIT=4 → cpu_stall_cycles=2, host_wait_cycles=8.
